// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit: opcodes, functs,
// ALU encodings, FSM states and the decoded control word.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_SLT     = 6'h2A;

    localparam int CNT_W         = 8;
    localparam int SYS_EXIT_CODE = 10;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_t;

    typedef enum logic [2:0] {
        S_FETCH    = 3'd0,
        S_DECODE   = 3'd1,
        S_EXEC     = 3'd2,
        S_MEM      = 3'd3,
        S_WB       = 3'd4,
        S_SYS_WAIT = 3'd5,
        S_HALT     = 3'd6
    } state_t;

    // Instruction class selects the path taken after EXEC.
    typedef enum logic [2:0] {
        CLS_FLOW    = 3'd0,
        CLS_ALU     = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_SYS     = 3'd4,
        CLS_ILLEGAL = 3'd5
    } iclass_t;

    typedef struct packed {
        iclass_t    iclass;
        logic [1:0] reg_dst;
        logic       jump;
        logic       branch;
        logic       jump_link;
        logic       jump_reg;
        logic       alu_src;
        logic       mem_to_reg;
        alu_op_t    alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
    } ctrl_word_t;

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational map from the instruction register to the control word;
// encodings match the original single-cycle decoder.
module ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [31:0] instr_i,
    output ctrl_word_t  cw_o
);

    logic [5:0] opcode;
    logic [5:0] funct;

    assign opcode = instr_i[31:26];
    assign funct  = instr_i[5:0];

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        cw_o        = '0;
        cw_o.iclass = CLS_FLOW;
        unique case (opcode)
            OP_SPECIAL: begin
                if (instr_i != 32'h0000_0000) begin
                    cw_o.iclass  = CLS_ALU;
                    cw_o.reg_dst = 2'd1;
                    cw_o.reg_write = 1'b1;
                    case (funct)
                        FN_ADD, FN_ADDU: cw_o.alu_op = ALU_ADD;
                        FN_SUB:          cw_o.alu_op = ALU_SUB;
                        FN_AND:          cw_o.alu_op = ALU_AND;
                        FN_OR:           cw_o.alu_op = ALU_OR;
                        FN_SLT:          cw_o.alu_op = ALU_SLT;
                        FN_JR: begin
                            cw_o          = '0;
                            cw_o.iclass   = CLS_FLOW;
                            cw_o.jump_reg = 1'b1;
                        end
                        FN_SYSCALL: begin
                            cw_o        = '0;
                            cw_o.iclass = CLS_SYS;
                        end
                        default: begin
                            cw_o        = '0;
                            cw_o.iclass = CLS_ILLEGAL;
                        end
                    endcase
                end
            end
            OP_ADDI, OP_ADDIU, OP_LUI, OP_ORI, OP_SLTIU: begin
                cw_o.iclass    = CLS_ALU;
                cw_o.alu_src   = 1'b1;
                cw_o.reg_write = 1'b1;
                cw_o.alu_op    = (opcode == OP_ORI)   ? ALU_OR  :
                                 (opcode == OP_SLTIU) ? ALU_SLT : ALU_ADD;
            end
            OP_LW: begin
                cw_o.iclass     = CLS_LOAD;
                cw_o.alu_src    = 1'b1;
                cw_o.alu_op     = ALU_ADD;
                cw_o.mem_read   = 1'b1;
                cw_o.mem_to_reg = 1'b1;
                cw_o.reg_write  = 1'b1;
            end
            OP_SW: begin
                cw_o.iclass    = CLS_STORE;
                cw_o.alu_src   = 1'b1;
                cw_o.alu_op    = ALU_ADD;
                cw_o.mem_write = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                cw_o.branch = 1'b1;
                cw_o.alu_op = ALU_SUB;
            end
            OP_J: cw_o.jump = 1'b1;
            OP_JAL: begin
                cw_o.iclass    = CLS_ALU;
                cw_o.jump      = 1'b1;
                cw_o.jump_link = 1'b1;
                cw_o.reg_dst   = 2'd2;
                cw_o.reg_write = 1'b1;
            end
            default: cw_o.iclass = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB with syscall handshake
// and halt. Define CTRL_ILLEGAL_TRAP_EN to trap unsupported encodings to HALT.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int MEM_WAIT_MAX = 15,
    parameter int SYS_WAIT_MAX = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] vreg,
    input  logic              mem_ready,
    input  logic              sys_ack,
    output logic              instr_ready,
    output logic [1:0]        RegDst,
    output logic              Jump,
    output logic              Branch,
    output logic              JumpLink,
    output logic              JumpReg,
    output logic              ALUSrc,
    output logic              MemToReg,
    output logic [2:0]        ALUop,
    output logic              MemRead,
    output logic              MemWrite,
    output logic              RegWrite,
    output logic              pc_write,
    output logic              sys_req,
    output logic [DATA_W-1:0] sys_code,
    output logic              halted,
    output logic              illegal,
    output logic [2:0]        state
);

    state_t            state_q, state_d;
    logic [31:0]       ir_q, ir_d;
    ctrl_word_t        cw_q, cw_d;
    ctrl_word_t        dec_cw;
    logic [DATA_W-1:0] sys_code_q, sys_code_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic              illegal_q, illegal_d;
    logic              hold;

    ctrl_decode u_decode (
        .instr_i (ir_q),
        .cw_o    (dec_cw)
    );

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_FETCH;
            ir_q       <= '0;
            cw_q       <= '0;
            sys_code_q <= '0;
            cnt_q      <= '0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            cw_q       <= cw_d;
            sys_code_q <= sys_code_d;
            cnt_q      <= cnt_d;
            illegal_q  <= illegal_d;
        end
    end

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        cw_d       = cw_q;
        sys_code_d = sys_code_q;
        cnt_d      = '0;
        illegal_d  = illegal_q;
        pc_write   = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                if (instr_valid) begin
                    ir_d    = instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                cw_d       = dec_cw;
                sys_code_d = vreg;
                state_d    = S_EXEC;
                if (dec_cw.iclass == CLS_SYS)
                    state_d = (vreg == DATA_W'(SYS_EXIT_CODE)) ? S_HALT : S_SYS_WAIT;
`ifdef CTRL_ILLEGAL_TRAP_EN
                if (dec_cw.iclass == CLS_ILLEGAL) begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end
`endif
            end
            S_EXEC: begin
                case (cw_q.iclass)
                    CLS_LOAD, CLS_STORE: state_d = S_MEM;
                    CLS_ALU:             state_d = S_WB;
                    default: begin
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (cw_q.iclass == CLS_LOAD) begin
                        state_d = S_WB;
                    end else begin
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end
                end else if (cnt_inc == CNT_W'(MEM_WAIT_MAX)) begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_WB: begin
                pc_write = 1'b1;
                state_d  = S_FETCH;
            end
            S_SYS_WAIT: begin
                if (sys_ack) begin
                    pc_write = 1'b1;
                    state_d  = S_FETCH;
                end else if (cnt_inc == CNT_W'(SYS_WAIT_MAX)) begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // Decoded controls are visible only while the instruction is past DECODE.
    assign hold = (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB);

    assign instr_ready = (state_q == S_FETCH) && !reset;
    assign RegDst      = hold ? cw_q.reg_dst : 2'd0;
    assign Jump        = hold && cw_q.jump;
    assign Branch      = hold && cw_q.branch;
    assign JumpLink    = hold && cw_q.jump_link;
    assign JumpReg     = hold && cw_q.jump_reg;
    assign ALUSrc      = hold && cw_q.alu_src;
    assign MemToReg    = hold && cw_q.mem_to_reg;
    assign ALUop       = hold ? cw_q.alu_op : 3'd0;
    assign MemRead     = (state_q == S_MEM) && cw_q.mem_read;
    assign MemWrite    = (state_q == S_MEM) && cw_q.mem_write;
    assign RegWrite    = (state_q == S_WB) && cw_q.reg_write;
    assign sys_req     = (state_q == S_SYS_WAIT);
    assign sys_code    = sys_code_q;
    assign halted      = (state_q == S_HALT);
    assign illegal     = illegal_q;
    assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: ALU, R-type, JAL, branch, LW/SW,
// syscall handshake, exit halt, timeout, reset mid-MEM and unsupported opcode.
module tb_multicycle_control;
    import mips_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] vreg;
    logic        mem_ready;
    logic        sys_ack;
    logic        instr_ready;
    logic [1:0]  RegDst;
    logic        Jump, Branch, JumpLink, JumpReg, ALUSrc, MemToReg;
    logic [2:0]  ALUop;
    logic        MemRead, MemWrite, RegWrite, pc_write, sys_req;
    logic [31:0] sys_code;
    logic        halted, illegal;
    logic [2:0]  state;
    logic [18:0] ctl;

    int checks = 0;
    int errors = 0;

    multicycle_control dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr       (instr),
        .vreg        (vreg),
        .mem_ready   (mem_ready),
        .sys_ack     (sys_ack),
        .instr_ready (instr_ready),
        .RegDst      (RegDst),
        .Jump        (Jump),
        .Branch      (Branch),
        .JumpLink    (JumpLink),
        .JumpReg     (JumpReg),
        .ALUSrc      (ALUSrc),
        .MemToReg    (MemToReg),
        .ALUop       (ALUop),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .RegWrite    (RegWrite),
        .pc_write    (pc_write),
        .sys_req     (sys_req),
        .sys_code    (sys_code),
        .halted      (halted),
        .illegal     (illegal),
        .state       (state)
    );

    assign ctl = {instr_ready, RegDst, Jump, Branch, JumpLink, JumpReg, ALUSrc, MemToReg,
                  ALUop, MemRead, MemWrite, RegWrite, pc_write, sys_req, halted, illegal};

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic ck(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample point is 1 ns after the falling edge.
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    // Present a word in FETCH; returns in the DECODE cycle.
    task automatic issue(input logic [31:0] w);
        instr_valid = 1'b1;
        instr       = w;
        cyc();
        instr_valid = 1'b0;
        instr       = '0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        ck("rst_state", state, S_FETCH);
        ck("rst_outs", ctl, 0);
        cyc();
        reset = 1'b0;
        #1;
        ck("rst_release_ready", instr_ready, 1);
    endtask

    initial begin
        reset = 1'b1; instr_valid = 1'b0; instr = '0; vreg = '0;
        mem_ready = 1'b0; sys_ack = 1'b0;
        cyc(); cyc();
        ck("init_state", state, S_FETCH);
        ck("init_outs", ctl, 0);
        ck("init_sys_code", sys_code, 0);
        reset = 1'b0;
        #1;
        ck("fetch_ready", instr_ready, 1);

        // ADDI $t0,$zero,5: F D E WB F
        issue(32'h2008_0005);
        ck("addi_dec_state", state, S_DECODE);
        ck("addi_dec_alusrc", ALUSrc, 0);
        ck("addi_dec_ready", instr_ready, 0);
        cyc();
        ck("addi_exec_state", state, S_EXEC);
        ck("addi_exec_alusrc", ALUSrc, 1);
        ck("addi_exec_aluop", ALUop, 3'b010);
        ck("addi_exec_regdst", RegDst, 0);
        ck("addi_exec_regwrite", RegWrite, 0);
        ck("addi_exec_pcw", pc_write, 0);
        cyc();
        ck("addi_wb_state", state, S_WB);
        ck("addi_wb_regwrite", RegWrite, 1);
        ck("addi_wb_pcw", pc_write, 1);
        cyc();
        ck("addi_back_state", state, S_FETCH);
        ck("addi_back_alusrc", ALUSrc, 0);
        ck("addi_back_regwrite", RegWrite, 0);

        // SUB $t0,$t1,$t2
        issue(32'h012A_4022);
        cyc();
        ck("sub_exec_regdst", RegDst, 1);
        ck("sub_exec_aluop", ALUop, 3'b110);
        ck("sub_exec_alusrc", ALUSrc, 0);
        cyc();
        ck("sub_wb_regwrite", RegWrite, 1);
        cyc();
        ck("sub_back_state", state, S_FETCH);

        // JAL
        issue(32'h0C00_0010);
        cyc();
        ck("jal_exec_regdst", RegDst, 2);
        ck("jal_exec_link", JumpLink, 1);
        ck("jal_exec_jump", Jump, 1);
        cyc();
        ck("jal_wb_state", state, S_WB);
        ck("jal_wb_regwrite", RegWrite, 1);
        cyc();
        ck("jal_back_state", state, S_FETCH);

        // BEQ: 3-cycle path
        issue(32'h1109_0003);
        cyc();
        ck("beq_exec_branch", Branch, 1);
        ck("beq_exec_aluop", ALUop, 3'b110);
        ck("beq_exec_pcw", pc_write, 1);
        cyc();
        ck("beq_back_state", state, S_FETCH);
        ck("beq_back_branch", Branch, 0);

        // LW with mem_ready on the 4th MEM cycle
        issue(32'h8C09_0004);
        cyc();
        ck("lw_exec_memtoreg", MemToReg, 1);
        ck("lw_exec_memread", MemRead, 0);
        cyc();
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            #1;
            ck("lw_mem_state", state, S_MEM);
            ck("lw_mem_memread", MemRead, 1);
            ck("lw_mem_pcw", pc_write, 0);
            cyc();
        end
        mem_ready = 1'b0;
        ck("lw_wb_state", state, S_WB);
        ck("lw_wb_regwrite", RegWrite, 1);
        ck("lw_wb_memread", MemRead, 0);
        ck("lw_wb_memtoreg", MemToReg, 1);
        cyc();
        ck("lw_back_state", state, S_FETCH);

        // NOP
        issue(32'h0000_0000);
        cyc();
        ck("nop_exec_state", state, S_EXEC);
        ck("nop_exec_pcw", pc_write, 1);
        ck("nop_exec_regwrite", RegWrite, 0);
        cyc();
        ck("nop_back_state", state, S_FETCH);

        // Stray sys_ack in FETCH has no effect
        sys_ack = 1'b1;
        #1;
        ck("stray_ack_pcw", pc_write, 0);
        cyc();
        sys_ack = 1'b0;
        ck("stray_ack_state", state, S_FETCH);
        ck("stray_ack_req", sys_req, 0);

        // SYSCALL print (vreg=4), ack on the 5th wait cycle
        vreg = 32'd4;
        issue(32'h0000_000C);
        ck("sys_dec_req", sys_req, 0);
        cyc();
        vreg = '0;
        ck("sys_code_latched", sys_code, 4);
        for (int i = 0; i < 5; i++) begin
            sys_ack = (i == 4);
            #1;
            ck("sys_wait_state", state, S_SYS_WAIT);
            ck("sys_wait_req", sys_req, 1);
            ck("sys_wait_pcw", pc_write, (i == 4) ? 1 : 0);
            cyc();
        end
        sys_ack = 1'b0;
        ck("sys_back_state", state, S_FETCH);
        ck("sys_back_req", sys_req, 0);

        // Unsupported opcode
        issue(32'hFC00_0000);
        cyc();
`ifdef CTRL_ILLEGAL_TRAP_EN
        ck("ill_trap_state", state, S_HALT);
        ck("ill_trap_flag", illegal, 1);
        ck("ill_trap_halted", halted, 1);
        pulse_reset();
`else
        ck("ill_nop_state", state, S_EXEC);
        ck("ill_nop_flag", illegal, 0);
        ck("ill_nop_pcw", pc_write, 1);
        cyc();
        ck("ill_nop_back", state, S_FETCH);
`endif

        // SW with reset asserted in MEM
        issue(32'hAD09_0008);
        cyc();
        cyc();
        cyc();
        ck("sw_rst_pre_state", state, S_MEM);
        ck("sw_rst_pre_memwrite", MemWrite, 1);
        pulse_reset();
        ck("sw_rst_sys_code", sys_code, 0);

        // SW with mem_ready held low: MEM_WAIT_MAX cycles then HALT
        issue(32'hAD09_0008);
        cyc();
        ck("sw_exec_alusrc", ALUSrc, 1);
        ck("sw_exec_memwrite", MemWrite, 0);
        cyc();
        for (int i = 0; i < 15; i++) begin
            ck("sw_to_state", state, S_MEM);
            ck("sw_to_memwrite", MemWrite, 1);
            ck("sw_to_illegal", illegal, 0);
            cyc();
        end
        ck("sw_to_halt_state", state, S_HALT);
        ck("sw_to_illegal_set", illegal, 1);
        ck("sw_to_halted", halted, 1);
        ck("sw_to_memwrite_off", MemWrite, 0);
        instr_valid = 1'b1;
        instr       = 32'h2008_0005;
        cyc();
        instr_valid = 1'b0;
        ck("halt_absorb_state", state, S_HALT);
        ck("halt_absorb_ready", instr_ready, 0);
        pulse_reset();
        ck("after_rst_illegal", illegal, 0);

        // Exit syscall: straight to HALT, no request
        vreg = 32'd10;
        issue(32'h0000_000C);
        ck("exit_dec_state", state, S_DECODE);
        cyc();
        vreg = '0;
        ck("exit_state", state, S_HALT);
        ck("exit_halted", halted, 1);
        ck("exit_req", sys_req, 0);
        ck("exit_illegal", illegal, 0);
        ck("exit_sys_code", sys_code, 10);
        cyc();
        ck("exit_hold_state", state, S_HALT);
        ck("exit_hold_req", sys_req, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
